fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, FSM state and FIFO entry type for the instruction fetch unit.
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam int unsigned FIFO_DEPTH       = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order response buffer holding {pc, data}; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         empty,
    output logic [1:0]   count
);
    fetch_entry_t mem_q [FIFO_DEPTH];
    fetch_entry_t mem_d [FIFO_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == 2'd0);
    assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: at most two fetches in flight plus buffered, redirect flush/drop.
// Optional FETCH_ALIGN_CHECK_EN adds a misaligned-redirect FAULT state and fetch_fault port.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instructionCode,
    output logic [31:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic [1:0]   out_q, out_d;
    logic [1:0]   drop_q, drop_d;
    logic [31:0]  redir_pc;
    logic         redir_bad;
    logic         grant, push, pop;
    logic [1:0]   fifo_count;
    logic         fifo_empty;
    fetch_entry_t fifo_head, push_entry;

    assign redir_pc = redirect_pc & ~32'd3;
`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) state_d = redir_bad ? ST_FAULT : ST_RUN;
    end

    always_comb begin
        imem_req = rst_n && (state_q == ST_RUN) && !redirect_valid &&
                   (({1'b0, out_q} + {1'b0, fifo_count}) < 3'(FIFO_DEPTH));
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_fault = (state_q == ST_FAULT);
`endif
    end

    assign grant = imem_req && imem_gnt;
    // Responses in the redirect cycle or still owed to a flushed stream never reach the FIFO.
    assign push  = imem_rvalid && !redirect_valid && (drop_q == 2'd0);
    assign pop   = instr_valid && instr_ready;
    assign push_entry = '{pc: resp_pc_q, data: imem_rdata};

    // resp_pc tracks the address of the next response that will be kept.
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q + {1'b0, grant} - {1'b0, imem_rvalid};
        drop_d    = drop_q;
        if (redirect_valid) begin
            pc_d      = redir_pc;
            resp_pc_d = redir_pc;
            drop_d    = out_q - {1'b0, imem_rvalid};
        end else begin
            if (grant)                         pc_d      = pc_q + PC_INC;
            if (push)                          resp_pc_d = resp_pc_q + PC_INC;
            if (imem_rvalid && drop_q != 2'd0) drop_d    = drop_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= 2'd0;
            drop_q    <= 2'd0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign imem_addr       = pc_q;
    assign instr_valid     = !fifo_empty;
    assign instructionCode = fifo_head.data;
    assign instr_pc        = fifo_head.pc;

    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (out_q != 2'd0));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with an in-order memory model.
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instructionCode;
    logic [31:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instructionCode (instructionCode),
        .instr_pc        (instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          gnt;
        bit          resp;
        bit          rdy;
        bit          rdr;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] pend[$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] code_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t v(input bit rst, input bit gnt, input bit resp, input bit rdy,
                               input bit rdr, input logic [31:0] rpc, input bit e_req,
                               input logic [31:0] e_addr, input bit e_iv, input logic [31:0] e_pc);
        vec_t t;
        t.rst = rst; t.gnt = gnt; t.resp = resp; t.rdy = rdy; t.rdr = rdr; t.rpc = rpc;
        t.e_req = e_req; t.e_addr = e_addr; t.e_iv = e_iv; t.e_pc = e_pc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        pend.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset imem_req", {31'd0, imem_req}, 32'd0);
        chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("reset fetch_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    endtask

    // One clock: memory returns the oldest granted request when resp is enabled.
    task automatic apply(input vec_t t, input int n);
        logic [31:0] a;
        if (t.rst) do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        if (t.resp && pend.size() > 0) begin
            a = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = code_of(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        imem_gnt       = t.gnt;
        instr_ready    = t.rdy;
        redirect_valid = t.rdr;
        redirect_pc    = t.rpc;
        @(negedge clk);
        if (imem_req && imem_gnt) pend.push_back(imem_addr);
        chk($sformatf("v%0d imem_req", n), {31'd0, imem_req}, {31'd0, t.e_req});
        if (t.e_req) chk($sformatf("v%0d imem_addr", n), imem_addr, t.e_addr);
        chk($sformatf("v%0d instr_valid", n), {31'd0, instr_valid}, {31'd0, t.e_iv});
        if (t.e_iv) begin
            chk($sformatf("v%0d instr_pc", n), instr_pc, t.e_pc);
            chk($sformatf("v%0d instructionCode", n), instructionCode, code_of(t.e_pc));
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        // streaming: grant always, response one cycle after grant, decoder always ready
        vecs.push_back(v(1,1,1,1,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h4,   0,0));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       1,32'h0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h8,   1,32'h4));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'hC,   0,0));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       1,32'h8));
        // decoder stalls: FIFO fills to two, requests stop until a pop
        vecs.push_back(v(1,1,1,0,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,1,1,0,0,0,            1,32'h4,   0,0));
        vecs.push_back(v(0,1,1,0,0,0,            0,0,       1,32'h0));
        vecs.push_back(v(0,1,1,0,0,0,            0,0,       1,32'h0));
        vecs.push_back(v(0,1,1,0,0,0,            0,0,       1,32'h0));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       1,32'h0));
        vecs.push_back(v(0,1,1,0,0,0,            1,32'h8,   1,32'h4));
        vecs.push_back(v(0,1,1,0,0,0,            0,0,       1,32'h4));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       1,32'h4));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'hC,   1,32'h8));
        // redirect with two outstanding: both late responses are dropped
        vecs.push_back(v(1,1,0,1,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,1,0,1,0,0,            1,32'h4,   0,0));
        vecs.push_back(v(0,1,0,1,1,32'h100,      0,0,       0,0));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h100, 0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h104, 0,0));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       1,32'h100));
        // redirect in the same cycle as a response
        vecs.push_back(v(1,1,1,0,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,1,1,0,0,0,            1,32'h4,   0,0));
        vecs.push_back(v(0,1,1,0,1,32'h40,       0,0,       1,32'h0));
        vecs.push_back(v(0,1,1,0,0,0,            1,32'h40,  0,0));
        vecs.push_back(v(0,1,1,0,0,0,            1,32'h44,  0,0));
        vecs.push_back(v(0,1,1,0,0,0,            0,0,       1,32'h40));
        // PC wrap at the top of the address space
        vecs.push_back(v(1,1,1,1,1,32'hFFFF_FFFC,0,0,       0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'hFFFF_FFFC, 0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       1,32'hFFFF_FFFC));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h4,   1,32'h0));
        // grant withheld: request and address hold
        vecs.push_back(v(1,0,1,1,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,0,1,1,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h0,   0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h4,   0,0));
        vecs.push_back(v(0,1,1,1,0,0,            0,0,       1,32'h0));
`ifndef FETCH_ALIGN_CHECK_EN
        // low redirect bits are ignored without the alignment check
        vecs.push_back(v(1,1,1,1,1,32'h103,      0,0,       0,0));
        vecs.push_back(v(0,1,1,1,0,0,            1,32'h100, 0,0));
`endif

        foreach (vecs[i]) apply(vecs[i], i);

        // reset with two requests in flight abandons them
        do_reset();
        apply(v(0,1,0,1,0,0, 1,32'h0, 0,0), 100);
        apply(v(0,1,0,1,0,0, 1,32'h4, 0,0), 101);
        do_reset();
        apply(v(0,1,1,1,0,0, 1,32'h0, 0,0), 102);
        apply(v(0,1,1,1,0,0, 1,32'h4, 0,0), 103);
        apply(v(0,1,1,1,0,0, 0,0,     1,32'h0), 104);

`ifdef FETCH_ALIGN_CHECK_EN
        do_reset();
        apply(v(0,1,1,1,1,32'h102, 0,0, 0,0), 200);
        chk("fault before edge", {31'd0, fetch_fault}, 32'd0);
        apply(v(0,1,1,1,0,0, 0,0, 0,0), 201);
        chk("fault set", {31'd0, fetch_fault}, 32'd1);
        apply(v(0,1,1,1,0,0, 0,0, 0,0), 202);
        chk("fault held", {31'd0, fetch_fault}, 32'd1);
        apply(v(0,1,1,1,1,32'h200, 0,0, 0,0), 203);
        chk("fault in redirect cycle", {31'd0, fetch_fault}, 32'd1);
        apply(v(0,1,1,1,0,0, 1,32'h200, 0,0), 204);
        chk("fault cleared", {31'd0, fetch_fault}, 32'd0);
        apply(v(0,1,1,1,0,0, 1,32'h204, 0,0), 205);
        apply(v(0,1,1,1,0,0, 0,0, 1,32'h200), 206);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
